// File: rtl/wb_demux_32_if.sv
// Write-back request bus and forwarding lookup port for wb_demux_32.
// master: request/lookup driver (drives in_*, stall, q_addr).
// slave : the demux (drives in_ready, we/waddr/wdata, q_hit/q_data, count).
interface wb_demux_32_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [WIDTH-1:0]  in_data;
    logic              stall;
    logic [NREG-1:0]   we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] q_addr;
    logic              q_hit;
    logic [WIDTH-1:0]  q_data;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_addr, in_data, stall, q_addr,
        input  in_ready, we, waddr, wdata, q_hit, q_data, count
    );

    modport slave (
        input  in_valid, in_addr, in_data, stall, q_addr,
        output in_ready, we, waddr, wdata, q_hit, q_data, count
    );
endinterface

// File: rtl/wb_demux_32.sv
// Register write-back demux: 2-entry request FIFO feeding a registered one-hot write-strobe decode.
// Latency: request accepted at edge N into an empty FIFO strobes after edge N+1; one strobe per cycle sustained.
// Backpressure: in_ready drops when the FIFO is full (no pass-through); stall holds the FIFO head.
// Ports: clock, reset_n (async active-low); bus.slave carries in_valid/in_ready/in_addr/in_data,
//        stall, we/waddr/wdata write strobes, q_addr/q_hit/q_data forwarding lookup, count occupancy.
module wb_demux_32 #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    wb_demux_32_if.slave bus
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [WIDTH-1:0]  mem_data [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [NREG-1:0]   we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [WIDTH-1:0]  wdata_q;

    logic              push;
    logic              pop;
    logic              ready;
    logic              hit;
    logic [WIDTH-1:0]  hit_data;
    logic [PTR_W-1:0]  idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ready = reset_n && (count_q < CNT_W'(DEPTH));
    // Address-0 writes are accepted on the handshake but never stored: register 0 is hardwired zero.
    assign push  = bus.in_valid && ready && (bus.in_addr != '0);
    assign pop   = (count_q != '0) && !bus.stall;

    // Payload storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_addr[tail_q] <= bus.in_addr;
            mem_data[tail_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            if (push) begin
                tail_q <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q  <= ptr_inc(head_q);
                we_q    <= NREG'(1) << mem_addr[head_q];
                waddr_q <= mem_addr[head_q];
                wdata_q <= mem_data[head_q];
            end else begin
                we_q <= '0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Forwarding lookup. Walk from lowest to highest priority so later matches override:
    // output stage first, then FIFO entries from oldest (head) to youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_q;
        if ((we_q != '0) && (waddr_q == bus.q_addr)) begin
            hit      = 1'b1;
            hit_data = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (mem_addr[idx] == bus.q_addr)) begin
                hit      = 1'b1;
                hit_data = mem_data[idx];
            end
            idx = ptr_inc(idx);
        end
        if (!reset_n || (bus.q_addr == '0)) begin
            hit      = 1'b0;
            hit_data = '0;
        end
    end

    assign bus.in_ready = ready;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.count    = count_q;
    assign bus.q_hit    = hit;
    assign bus.q_data   = hit_data;
endmodule

// File: tb/tb_wb_demux_32.sv
// Bench for wb_demux_32: directed scenarios followed by random traffic, all checked
// against a queue-based model of the pending writes and the last issued strobe.
module tb_wb_demux_32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    ent_t        mq[$];
    logic [31:0] m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    wb_demux_32_if #(.WIDTH(32), .ADDR_W(5), .DEPTH(DEPTH)) bus ();

    wb_demux_32 #(.WIDTH(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest pending write wins, then the strobe currently being issued.
    function automatic void ref_lookup(input logic [4:0] qa, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (!reset_n || qa == 5'd0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == qa) begin
                h = 1'b1;
                d = mq[i].d;
                return;
            end
        end
        if (m_we != 0 && m_waddr == qa) begin
            h = 1'b1;
            d = m_wdata;
        end
    endfunction

    task automatic check_lookup(input string tag);
        logic        h;
        logic [31:0] d;
        ref_lookup(bus.q_addr, h, d);
        chk({tag, "_q_hit"}, bus.q_hit, h);
        chk({tag, "_q_data"}, bus.q_data, d);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_count"}, bus.count, mq.size());
        chk({tag, "_in_ready"}, bus.in_ready, reset_n && (mq.size() < DEPTH));
        chk({tag, "_we"}, bus.we, m_we);
        chk({tag, "_waddr"}, bus.waddr, m_waddr);
        chk({tag, "_wdata"}, bus.wdata, m_wdata);
        check_lookup(tag);
    endtask

    task automatic model_clear();
        mq.delete();
        m_we    = '0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // One clock edge: model decides transfer/pop from pre-edge state, then all outputs are compared.
    task automatic tick(input string tag);
        logic acc;
        logic pp;
        ent_t e;
        acc = reset_n && bus.in_valid && (mq.size() < DEPTH);
        pp  = reset_n && (mq.size() > 0) && !bus.stall;
        @(posedge clock);
        if (!reset_n) begin
            model_clear();
        end else begin
            if (pp) begin
                e       = mq.pop_front();
                m_we    = 32'd1 << e.a;
                m_waddr = e.a;
                m_wdata = e.d;
            end else begin
                m_we = '0;
            end
            if (acc && bus.in_addr != 5'd0) begin
                e.a = bus.in_addr;
                e.d = bus.in_data;
                mq.push_back(e);
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic req(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.stall    = 1'b0;
        bus.q_addr   = 5'd7;
        req(1'b0, 5'd0, 32'd0);
        model_clear();

        // Reset state
        #3;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_count", bus.count, 2'd0);
        chk("rst_we", bus.we, 32'd0);
        chk("rst_q_hit", bus.q_hit, 1'b0);
        #9 reset_n = 1'b1;
        #1 check_all("post_rst");

        // Single write to r7
        @(posedge clock); #1;
        req(1'b1, 5'd7, 32'hDEADBEEF);
        tick("t1_acc");
        req(1'b0, 5'd0, 32'd0);
        tick("t1_pop");
        chk("t1_we", bus.we, 32'h0000_0080);
        chk("t1_waddr", bus.waddr, 5'd7);
        chk("t1_wdata", bus.wdata, 32'hDEADBEEF);
        chk("t1_count", bus.count, 2'd0);
        tick("t1_after");
        chk("t1_we_pulse", bus.we, 32'd0);

        // Fill under stall, third request held off
        bus.stall = 1'b1;
        req(1'b1, 5'd3, 32'h11);
        tick("t2_push3");
        req(1'b1, 5'd4, 32'h22);
        tick("t2_push4");
        chk("t2_count_full", bus.count, 2'd2);
        chk("t2_ready_full", bus.in_ready, 1'b0);
        req(1'b1, 5'd6, 32'h33);
        tick("t2_held");
        chk("t2_count_held", bus.count, 2'd2);
        bus.stall = 1'b0;
        tick("t2_pop3");
        chk("t2_we3", bus.we, 32'h8);
        tick("t2_pop4");
        chk("t2_we4", bus.we, 32'h10);
        chk("t2_third_acc", bus.count, 2'd1);
        req(1'b0, 5'd0, 32'd0);
        tick("t2_pop6");
        chk("t2_we6", bus.we, 32'h40);

        // Register-0 drop
        bus.q_addr = 5'd0;
        req(1'b1, 5'd0, 32'hFFFF);
        tick("t3_r0");
        chk("t3_count", bus.count, 2'd0);
        chk("t3_q_hit", bus.q_hit, 1'b0);
        req(1'b0, 5'd0, 32'd0);
        tick("t3_after");
        chk("t3_we", bus.we, 32'd0);

        // Forwarding priority
        bus.stall = 1'b1;
        req(1'b1, 5'd9, 32'hA);
        tick("t4_pushA");
        req(1'b1, 5'd9, 32'hB);
        tick("t4_pushB");
        req(1'b0, 5'd0, 32'd0);
        bus.q_addr = 5'd9;
        #1;
        chk("t4_hit", bus.q_hit, 1'b1);
        chk("t4_young", bus.q_data, 32'hB);
        bus.stall = 1'b0;
        tick("t4_popA");
        bus.stall = 1'b1;
        #1;
        chk("t4_after_pop", bus.q_data, 32'hB);
        bus.q_addr = 5'd10;
        #1;
        chk("t4_miss", bus.q_hit, 1'b0);
        bus.stall = 1'b0;
        tick("t4_popB");
        tick("t4_idle");

        // Simultaneous push/pop at count 1
        bus.stall = 1'b1;
        req(1'b1, 5'd5, 32'h500);
        tick("t5_prime");
        bus.stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req(1'b1, 5'd5, 32'h501 + i);
            tick("t5_stream");
            chk("t5_count", bus.count, 2'd1);
            chk("t5_we", bus.we, 32'h20);
        end

        // Async reset mid-stream with a strobe in flight
        bus.q_addr = 5'd5;
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        chk("t6_we", bus.we, 32'd0);
        chk("t6_count", bus.count, 2'd0);
        chk("t6_waddr", bus.waddr, 5'd0);
        chk("t6_wdata", bus.wdata, 32'd0);
        chk("t6_ready", bus.in_ready, 1'b0);
        chk("t6_q_hit", bus.q_hit, 1'b0);
        tick("t6_in_rst");
        req(1'b0, 5'd0, 32'd0);
        tick("t6_in_rst2");
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("t6_lost");
            chk("t6_no_strobe", bus.we, 32'd0);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req(($urandom % 4) != 0, 5'($urandom_range(0, 7)), $urandom);
            bus.stall  = ($urandom % 3) == 0;
            bus.q_addr = 5'($urandom_range(0, 7));
            tick("rand");
        end
        req(1'b0, 5'd0, 32'd0);
        bus.stall = 1'b0;
        for (int i = 0; i < 4; i++) tick("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
